// File: rtl/memory_stage_if.sv
// ----------------------------------------------------------------------------
// memory_stage_if
//   Data-memory bus between the MEM pipeline stage (master) and the data
//   memory (slave). Request/grant/response handshake:
//     dmem_req    master->slave  request pending; held until dmem_gnt
//     dmem_we     master->slave  1 = write, 0 = read
//     dmem_addr   master->slave  dword-aligned address
//     dmem_wdata  master->slave  lane-shifted store data
//     dmem_wstrb  master->slave  byte enables
//     dmem_gnt    slave->master  request accepted
//     dmem_rvalid slave->master  response: read data valid / write done
//     dmem_rdata  slave->master  read dword
// ----------------------------------------------------------------------------
interface memory_stage_if #(
    parameter int unsigned XLEN = 64
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [7:0]      dmem_wstrb;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_gnt,
        input  dmem_rvalid,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_gnt,
        output dmem_rvalid,
        output dmem_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// ----------------------------------------------------------------------------
// memory_stage
//   MEM pipeline stage. Accepts one result from EX, either passes an ALU result
//   straight to WB or runs a load/store over the data-memory bus, extends load
//   data and reports the result to WB and to the EX forwarding path.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   EXMEM_ready       EX result valid this cycle (sampled only while idle)
//   exmm_aluresult    ALU result, or effective address for memory ops
//   dest_reg          destination register (0 reported as RD_NONE)
//   mem_active        instruction accesses memory
//   load              1 = load, 0 = store
//   mem_size          0 byte, 1 half, 2 word, 3 dword
//   mem_unsigned      zero-extend load data
//   store_data        right-aligned store value
//   MEMEX_stall       EX must hold its inputs (stage busy)
//   MEMEX_rd/rdval    forwarding pair (RD_NONE while a memory op is in flight)
//   dmem              data-memory bus, master side
//   MEMWB_ready       one-cycle pulse: MEMWB_rd/rdval valid
//   MEMWB_rd/rdval    write-back destination and value
//   mem_misalign      one-cycle pulse: misaligned access was dropped
// ----------------------------------------------------------------------------
module memory_stage #(
    parameter int unsigned XLEN    = 64,
    parameter logic [5:0]  RD_NONE = 6'h3F
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              EXMEM_ready,
    input  logic [XLEN-1:0]   exmm_aluresult,
    input  logic [5:0]        dest_reg,
    input  logic              mem_active,
    input  logic              load,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [XLEN-1:0]   store_data,

    output logic              MEMEX_stall,
    output logic [5:0]        MEMEX_rd,
    output logic [XLEN-1:0]   MEMEX_rdval,

    memory_stage_if.master    dmem,

    output logic              MEMWB_ready,
    output logic [5:0]        MEMWB_rd,
    output logic [XLEN-1:0]   MEMWB_rdval,
    output logic              mem_misalign
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e            state_q;

    // Bus outputs, held stable from request until grant.
    logic              req_q;
    logic              we_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [7:0]        wstrb_q;

    // Captured op attributes needed when the response arrives.
    logic [2:0]        lane_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              load_q;
    logic [5:0]        dest_q;

    // Write-back registers; also the persistent forwarding source.
    logic              wb_ready_q;
    logic [5:0]        wb_rd_q;
    logic [XLEN-1:0]   wb_val_q;
    logic              misalign_q;

    // Combinational helpers.
    logic [2:0]        size_mask;
    logic [7:0]        lane_mask;
    logic              misaligned;
    logic [7:0]        st_strb;
    logic [XLEN-1:0]   st_data;
    logic [5:0]        norm_rd;
    logic [XLEN-1:0]   ld_shift;
    logic [XLEN-1:0]   ld_val;

    always_comb begin
        size_mask = 3'b000;
        lane_mask = 8'h01;
        unique case (mem_size)
            2'd0: begin size_mask = 3'b000; lane_mask = 8'h01; end
            2'd1: begin size_mask = 3'b001; lane_mask = 8'h03; end
            2'd2: begin size_mask = 3'b011; lane_mask = 8'h0F; end
            2'd3: begin size_mask = 3'b111; lane_mask = 8'hFF; end
        endcase

        misaligned = |(exmm_aluresult[2:0] & size_mask);
        st_strb    = lane_mask << exmm_aluresult[2:0];
        st_data    = store_data << {exmm_aluresult[2:0], 3'b000};
        norm_rd    = (dest_reg == 6'd0) ? RD_NONE : dest_reg;

        // Bring the addressed lane down to bit 0, then extend per access size.
        ld_shift = dmem.dmem_rdata >> {lane_q, 3'b000};
        ld_val   = ld_shift;
        unique case (size_q)
            2'd0: ld_val = uns_q ? {{(XLEN-8){1'b0}}, ld_shift[7:0]}
                                 : {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            2'd1: ld_val = uns_q ? {{(XLEN-16){1'b0}}, ld_shift[15:0]}
                                 : {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            2'd2: ld_val = uns_q ? {{(XLEN-32){1'b0}}, ld_shift[31:0]}
                                 : {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
            2'd3: ld_val = ld_shift;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= 8'h00;
            lane_q     <= 3'd0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            load_q     <= 1'b0;
            dest_q     <= RD_NONE;
            wb_ready_q <= 1'b0;
            wb_rd_q    <= RD_NONE;
            wb_val_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            wb_ready_q <= 1'b0;
            misalign_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (EXMEM_ready) begin
                        if (!mem_active) begin
                            wb_ready_q <= 1'b1;
                            wb_rd_q    <= norm_rd;
                            wb_val_q   <= exmm_aluresult;
                        end else if (misaligned) begin
                            // Dropped: no bus traffic, no write-back.
                            misalign_q <= 1'b1;
                        end else begin
                            state_q <= StReq;
                            req_q   <= 1'b1;
                            we_q    <= !load;
                            addr_q  <= {exmm_aluresult[XLEN-1:3], 3'b000};
                            wdata_q <= load ? '0 : st_data;
                            wstrb_q <= st_strb;
                            lane_q  <= exmm_aluresult[2:0];
                            size_q  <= mem_size;
                            uns_q   <= mem_unsigned;
                            load_q  <= load;
                            dest_q  <= norm_rd;
                        end
                    end
                end
                StReq: begin
                    if (dmem.dmem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (dmem.dmem_rvalid) begin
                        state_q    <= StIdle;
                        wb_ready_q <= 1'b1;
                        if (load_q) begin
                            wb_rd_q  <= dest_q;
                            wb_val_q <= ld_val;
                        end else begin
                            wb_rd_q  <= RD_NONE;
                            wb_val_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign MEMEX_stall     = (state_q != StIdle);
    // Load data is not known until the response, so hide the register id meanwhile.
    assign MEMEX_rd        = (state_q == StIdle) ? wb_rd_q : RD_NONE;
    assign MEMEX_rdval     = wb_val_q;

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_wstrb = wstrb_q;

    assign MEMWB_ready     = wb_ready_q;
    assign MEMWB_rd        = wb_rd_q;
    assign MEMWB_rdval     = wb_val_q;
    assign mem_misalign    = misalign_q;

endmodule

// File: tb/tb_memory_stage.sv
// ----------------------------------------------------------------------------
// tb_memory_stage
//   Self-checking bench for memory_stage: hand-written vector table, a
//   randomized run against a behavioural model, and reset/idle corner cases.
// ----------------------------------------------------------------------------
module tb_memory_stage;

    localparam logic [5:0] RDN = 6'h3F;

    logic        clk = 1'b0;
    logic        reset;
    logic        EXMEM_ready;
    logic [63:0] exmm_aluresult;
    logic [5:0]  dest_reg;
    logic        mem_active;
    logic        load;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [63:0] store_data;
    logic        MEMEX_stall;
    logic [5:0]  MEMEX_rd;
    logic [63:0] MEMEX_rdval;
    logic        MEMWB_ready;
    logic [5:0]  MEMWB_rd;
    logic [63:0] MEMWB_rdval;
    logic        mem_misalign;

    memory_stage_if bus ();

    memory_stage dut (
        .clk            (clk),
        .reset          (reset),
        .EXMEM_ready    (EXMEM_ready),
        .exmm_aluresult (exmm_aluresult),
        .dest_reg       (dest_reg),
        .mem_active     (mem_active),
        .load           (load),
        .mem_size       (mem_size),
        .mem_unsigned   (mem_unsigned),
        .store_data     (store_data),
        .MEMEX_stall    (MEMEX_stall),
        .MEMEX_rd       (MEMEX_rd),
        .MEMEX_rdval    (MEMEX_rdval),
        .dmem           (bus),
        .MEMWB_ready    (MEMWB_ready),
        .MEMWB_rd       (MEMWB_rd),
        .MEMWB_rdval    (MEMWB_rdval),
        .mem_misalign   (mem_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        act;
        logic        ld;
        logic [1:0]  sz;
        logic        uns;
        logic [63:0] addr;   // ALU result or effective address
        logic [63:0] sdata;
        logic [63:0] rdata;
        logic [5:0]  dest;
        int          gdly;
        int          rdly;
        logic        mis;
        logic [5:0]  erd;
        logic [63:0] eval;
        logic [7:0]  estrb;
        logic [63:0] ewdata;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [5:0]  last_rd  = RDN;
    logic [63:0] last_val = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic act, input logic ld, input logic [1:0] sz,
                                input logic uns, input logic [63:0] addr,
                                input logic [63:0] sdata, input logic [63:0] rdata,
                                input logic [5:0] dest, input int gdly, input int rdly,
                                input logic mis, input logic [5:0] erd,
                                input logic [63:0] eval, input logic [7:0] estrb,
                                input logic [63:0] ewdata);
        vec_t v;
        v.act = act; v.ld = ld; v.sz = sz; v.uns = uns; v.addr = addr;
        v.sdata = sdata; v.rdata = rdata; v.dest = dest; v.gdly = gdly; v.rdly = rdly;
        v.mis = mis; v.erd = erd; v.eval = eval; v.estrb = estrb; v.ewdata = ewdata;
        return v;
    endfunction

    // Reference: derives expectations from the access rules with plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t        r = v;
        int          nb = 1 << v.sz;
        int          lane = int'(v.addr % 8);
        logic [63:0] mask;
        logic [63:0] val;
        logic [5:0]  rd = (v.dest == 6'd0) ? RDN : v.dest;
        r.mis    = v.act && ((v.addr % 64'(nb)) != 0);
        r.estrb  = '0;
        r.ewdata = v.sdata << (8 * lane);
        if (!r.mis)
            for (int i = 0; i < nb; i++) r.estrb[lane + i] = 1'b1;
        if (!v.act) begin
            r.erd = rd; r.eval = v.addr;
        end else if (v.ld) begin
            mask = (nb == 8) ? {64{1'b1}} : ((64'd1 << (8 * nb)) - 64'd1);
            val  = (v.rdata >> (8 * lane)) & mask;
            if (!v.uns && nb < 8 && val[8 * nb - 1]) val = val | ~mask;
            r.erd = rd; r.eval = val;
        end else begin
            r.erd = RDN; r.eval = '0;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from idle, play the memory side, and check every cycle.
    task automatic run_op(input vec_t v, input string tag);
        logic [63:0] a0, w0;
        logic [7:0]  s0;
        EXMEM_ready    = 1'b1;
        exmm_aluresult = v.addr;
        dest_reg       = v.dest;
        mem_active     = v.act;
        load           = v.ld;
        mem_size       = v.sz;
        mem_unsigned   = v.uns;
        store_data     = v.sdata;
        step();
        EXMEM_ready    = 1'b0;
        exmm_aluresult = {$urandom, $urandom};
        store_data     = {$urandom, $urandom};
        if (!v.act) begin
            chk({tag, " alu wb_ready"}, 64'(MEMWB_ready), 64'd1);
            chk({tag, " alu wb_rd"}, 64'(MEMWB_rd), 64'(v.erd));
            chk({tag, " alu wb_val"}, MEMWB_rdval, v.eval);
            chk({tag, " alu ex_rd"}, 64'(MEMEX_rd), 64'(v.erd));
            chk({tag, " alu ex_val"}, MEMEX_rdval, v.eval);
            chk({tag, " alu stall"}, 64'(MEMEX_stall), 64'd0);
            chk({tag, " alu req"}, 64'(bus.dmem_req), 64'd0);
            last_rd = v.erd; last_val = v.eval;
            step();
            chk({tag, " alu pulse end"}, 64'(MEMWB_ready), 64'd0);
        end else if (v.mis) begin
            chk({tag, " mis pulse"}, 64'(mem_misalign), 64'd1);
            chk({tag, " mis req"}, 64'(bus.dmem_req), 64'd0);
            chk({tag, " mis wb_ready"}, 64'(MEMWB_ready), 64'd0);
            chk({tag, " mis stall"}, 64'(MEMEX_stall), 64'd0);
            chk({tag, " mis ex_rd keep"}, 64'(MEMEX_rd), 64'(last_rd));
            chk({tag, " mis ex_val keep"}, MEMEX_rdval, last_val);
            step();
            chk({tag, " mis pulse end"}, 64'(mem_misalign), 64'd0);
            chk({tag, " mis req later"}, 64'(bus.dmem_req), 64'd0);
        end else begin
            chk({tag, " req"}, 64'(bus.dmem_req), 64'd1);
            chk({tag, " stall"}, 64'(MEMEX_stall), 64'd1);
            chk({tag, " we"}, 64'(bus.dmem_we), 64'(!v.ld));
            chk({tag, " addr"}, bus.dmem_addr, {v.addr[63:3], 3'b000});
            chk({tag, " ex_rd hidden"}, 64'(MEMEX_rd), 64'(RDN));
            chk({tag, " wb_ready early"}, 64'(MEMWB_ready), 64'd0);
            if (!v.ld) begin
                chk({tag, " wstrb"}, 64'(bus.dmem_wstrb), 64'(v.estrb));
                chk({tag, " wdata"}, bus.dmem_wdata, v.ewdata);
            end
            a0 = bus.dmem_addr; w0 = bus.dmem_wdata; s0 = bus.dmem_wstrb;
            for (int i = 0; i < v.gdly; i++) begin
                step();
                chk({tag, " req held"}, 64'(bus.dmem_req), 64'd1);
                chk({tag, " addr held"}, bus.dmem_addr, a0);
                chk({tag, " wdata held"}, bus.dmem_wdata, w0);
                chk({tag, " wstrb held"}, 64'(bus.dmem_wstrb), 64'(s0));
                chk({tag, " stall gnt wait"}, 64'(MEMEX_stall), 64'd1);
                chk({tag, " wb_ready gnt wait"}, 64'(MEMWB_ready), 64'd0);
            end
            bus.dmem_gnt = 1'b1;
            step();
            bus.dmem_gnt = 1'b0;
            chk({tag, " req drop"}, 64'(bus.dmem_req), 64'd0);
            chk({tag, " stall resp"}, 64'(MEMEX_stall), 64'd1);
            for (int i = 0; i < v.rdly; i++) begin
                step();
                chk({tag, " stall resp wait"}, 64'(MEMEX_stall), 64'd1);
                chk({tag, " wb_ready resp wait"}, 64'(MEMWB_ready), 64'd0);
                chk({tag, " req resp wait"}, 64'(bus.dmem_req), 64'd0);
            end
            bus.dmem_rvalid = 1'b1;
            bus.dmem_rdata  = v.rdata;
            step();
            bus.dmem_rvalid = 1'b0;
            bus.dmem_rdata  = {$urandom, $urandom};
            chk({tag, " wb_ready"}, 64'(MEMWB_ready), 64'd1);
            chk({tag, " wb_rd"}, 64'(MEMWB_rd), 64'(v.erd));
            chk({tag, " wb_val"}, MEMWB_rdval, v.eval);
            chk({tag, " ex_rd"}, 64'(MEMEX_rd), 64'(v.erd));
            chk({tag, " ex_val"}, MEMEX_rdval, v.eval);
            chk({tag, " stall done"}, 64'(MEMEX_stall), 64'd0);
            last_rd = v.erd; last_val = v.eval;
            step();
            chk({tag, " wb pulse end"}, 64'(MEMWB_ready), 64'd0);
        end
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        // Hand-computed vectors: act ld sz uns addr sdata rdata dest gdly rdly
        //                        mis erd eval estrb ewdata
        tbl[0] = mk(0, 0, 2'd0, 0, 64'h1234, 0, 0, 6'd5, 0, 0,
                    0, 6'd5, 64'h1234, 0, 0);
        tbl[1] = mk(1, 1, 2'd0, 0, 64'h1003, 0, 64'h0000_0000_8000_0000, 6'd7, 0, 0,
                    0, 6'd7, 64'hFFFF_FFFF_FFFF_FF80, 0, 0);
        tbl[2] = mk(1, 1, 2'd0, 1, 64'h1003, 0, 64'h0000_0000_8000_0000, 6'd7, 1, 1,
                    0, 6'd7, 64'h80, 0, 0);
        tbl[3] = mk(1, 0, 2'd1, 0, 64'h2006, 64'hBEEF, 0, 6'd9, 0, 0,
                    0, RDN, 64'h0, 8'hC0, 64'hBEEF_0000_0000_0000);
        tbl[4] = mk(1, 1, 2'd2, 0, 64'h1004, 0, 64'h89AB_CDEF_0123_4567, 6'd10, 3, 2,
                    0, 6'd10, 64'hFFFF_FFFF_89AB_CDEF, 0, 0);
        tbl[5] = mk(1, 1, 2'd2, 0, 64'h3002, 0, 0, 6'd11, 0, 0,
                    1, 6'd0, 64'h0, 0, 0);
        tbl[6] = mk(1, 1, 2'd3, 0, 64'h40, 0, 64'h0123_4567_89AB_CDEF, 6'd0, 0, 1,
                    0, RDN, 64'h0123_4567_89AB_CDEF, 0, 0);
        tbl[7] = mk(1, 1, 2'd1, 1, 64'h2, 0, 64'h0000_0000_F00D_0000, 6'd12, 2, 0,
                    0, 6'd12, 64'hF00D, 0, 0);
        tbl[8] = mk(1, 1, 2'd1, 0, 64'h2, 0, 64'h0000_0000_F00D_0000, 6'd13, 0, 0,
                    0, 6'd13, 64'hFFFF_FFFF_FFFF_F00D, 0, 0);
        tbl[9] = mk(1, 0, 2'd3, 0, 64'h8, 64'h1122_3344_5566_7788, 0, 6'd14, 1, 2,
                    0, RDN, 64'h0, 8'hFF, 64'h1122_3344_5566_7788);

        reset = 1'b1;
        EXMEM_ready = 1'b0; exmm_aluresult = '0; dest_reg = '0; mem_active = 1'b0;
        load = 1'b0; mem_size = '0; mem_unsigned = 1'b0; store_data = '0;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
        step();
        step();
        chk("reset stall", 64'(MEMEX_stall), 64'd0);
        chk("reset ex_rd", 64'(MEMEX_rd), 64'(RDN));
        chk("reset wb_rd", 64'(MEMWB_rd), 64'(RDN));
        chk("reset wb_ready", 64'(MEMWB_ready), 64'd0);
        chk("reset req", 64'(bus.dmem_req), 64'd0);
        chk("reset wb_val", MEMWB_rdval, 64'd0);
        chk("reset misalign", 64'(mem_misalign), 64'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        // Stray grant/response while idle must be ignored.
        bus.dmem_gnt = 1'b1; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 64'hDEAD;
        step();
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
        chk("idle stray wb_ready", 64'(MEMWB_ready), 64'd0);
        chk("idle stray stall", 64'(MEMEX_stall), 64'd0);
        chk("idle stray req", 64'(bus.dmem_req), 64'd0);
        chk("idle stray ex_rd", 64'(MEMEX_rd), 64'(last_rd));

        // Reset arriving while waiting for the response.
        EXMEM_ready = 1'b1; mem_active = 1'b1; load = 1'b1; mem_size = 2'd2;
        mem_unsigned = 1'b0; exmm_aluresult = 64'h100; dest_reg = 6'd3;
        step();
        EXMEM_ready = 1'b0;
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0;
        chk("rst pre stall", 64'(MEMEX_stall), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst async req", 64'(bus.dmem_req), 64'd0);
        chk("rst async stall", 64'(MEMEX_stall), 64'd0);
        chk("rst async wb_rd", 64'(MEMWB_rd), 64'(RDN));
        step();
        reset = 1'b0;
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 64'h1111_2222_3333_4444;
        step();
        bus.dmem_rvalid = 1'b0;
        chk("rst late rvalid wb_ready", 64'(MEMWB_ready), 64'd0);
        chk("rst late rvalid wb_rd", 64'(MEMWB_rd), 64'(RDN));
        chk("rst late rvalid stall", 64'(MEMEX_stall), 64'd0);
        last_rd = RDN; last_val = '0;

        // Randomized ops against the model.
        for (int n = 0; n < 150; n++) begin
            rv.act   = ($urandom_range(0, 3) != 0);
            rv.ld    = $urandom_range(0, 1) == 1;
            rv.sz    = 2'($urandom_range(0, 3));
            rv.uns   = $urandom_range(0, 1) == 1;
            rv.addr  = {$urandom, $urandom};
            if ($urandom_range(0, 4) != 0) rv.addr = rv.addr & ~((64'd1 << rv.sz) - 64'd1);
            rv.sdata = {$urandom, $urandom};
            rv.rdata = {$urandom, $urandom};
            rv.dest  = 6'($urandom_range(0, 63));
            rv.gdly  = $urandom_range(0, 3);
            rv.rdly  = $urandom_range(0, 3);
            rv = model(rv);
            run_op(rv, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
